// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit: MEM-stage load/store initiator driving a single-port DataMemory.
// Sub-word stores are done as read-modify-write; loads are extracted and extended
// from the addressed lane. The pipeline is stalled while an access is in flight.
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              misalign_err,
    output logic              Mem_read,
    output logic              Mem_write,
    output logic [ADDR_W-1:0] Mem_address,
    output logic [31:0]       Write_data,
    input  logic [31:0]       Read_Data
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RDWAIT = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    // Registered state and latched request
    state_e              state_q,      state_d;
    logic                load_q,       load_d;
    logic [1:0]          size_q,       size_d;
    logic                uns_q,        uns_d;
    logic [1:0]          lane_q,       lane_d;
    logic [HALF_W-1:0]   sdata_q,      sdata_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic                mem_read_q,   mem_read_d;
    logic                mem_write_q,  mem_write_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    // Request decode
    logic                req_go;
    logic                req_word;
    logic                misaligned;
    logic                accept;
    logic [1:0]          req_lane;

    // Read datapath
    logic [BYTE_W-1:0]   rd_byte;
    logic [HALF_W-1:0]   rd_half;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   merged;

    // Decode the incoming request: alignment, acceptance and effective byte lane
    always_comb begin
        req_go     = req_valid & (req_load | req_store);
        req_word   = req_size[1];
        misaligned = (ALIGN_CHECK != 0) &&
                     (((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_word && (req_addr[1:0] != 2'b00)));
        accept     = (state_q == S_IDLE) && req_go && !misaligned;
        unique case (req_size)
            SZ_BYTE: req_lane = req_addr[1:0];
            SZ_HALF: req_lane = {req_addr[1], 1'b0};
            default: req_lane = 2'b00;
        endcase
    end

    // Extract/extend the loaded lane and merge store data into the read word
    always_comb begin
        rd_byte = Read_Data[{lane_q, 3'b000} +: BYTE_W];
        rd_half = Read_Data[{lane_q[1], 4'b0000} +: HALF_W];
        merged  = Read_Data;
        unique case (size_q)
            SZ_BYTE: begin
                load_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                merged[{lane_q, 3'b000} +: BYTE_W] = sdata_q[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                merged[{lane_q[1], 4'b0000} +: HALF_W] = sdata_q;
            end
            default: begin
                load_ext = Read_Data;
            end
        endcase
    end

    // FSM next state, request latching and next values of registered outputs
    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        sdata_d      = sdata_q;
        mem_addr_d   = mem_addr_q;
        write_data_d = write_data_q;
        resp_rdata_d = resp_rdata_q;
        stall        = 1'b0;
        misalign_err = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                misalign_err = req_go & misaligned;
                if (accept) begin
                    stall      = 1'b1;
                    load_d     = req_load;
                    size_d     = req_size;
                    uns_d      = req_unsigned;
                    lane_d     = req_lane;
                    sdata_d    = req_wdata[HALF_W-1:0];
                    mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    if (req_load || !req_word) begin
                        state_d = S_RD;
                    end else begin
                        state_d      = S_WR;
                        write_data_d = req_wdata;
                    end
                end
            end
            S_RD: begin
                stall   = 1'b1;
                state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                stall = 1'b1;
                if (load_q) begin
                    resp_rdata_d = load_ext;
                    state_d      = S_RESP;
                end else begin
                    write_data_d = merged;
                    state_d      = S_WR;
                end
            end
            S_WR: begin
                stall   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_read_d   = (state_d == S_RD);
        mem_write_d  = (state_d == S_WR);
        resp_valid_d = (state_d == S_RESP);
    end

    // State and output registers; reset drops any in-flight access immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_q       <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            sdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            write_data_q <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            sdata_q      <= sdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            write_data_q <= write_data_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign Mem_read    = mem_read_q;
    assign Mem_write   = mem_write_q;
    assign Mem_address = mem_addr_q;
    assign Write_data  = write_data_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// tb_mem_access_unit: directed + random load/store traffic against a byte-level
// reference memory; a negedge monitor checks every cycle against queued expectations.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_load, req_store, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall, resp_valid, misalign_err, Mem_read, Mem_write;
    logic [31:0]       resp_rdata, Write_data, Read_Data;
    logic [ADDR_W-1:0] Mem_address;

    mem_access_unit #(.ADDR_W(ADDR_W), .ALIGN_CHECK(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misalign_err(misalign_err),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .Mem_address(Mem_address),
        .Write_data(Write_data), .Read_Data(Read_Data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        int          lat;
        bit          is_load;
        bit          is_store;
        bit          needs_rd;
        logic [31:0] addr_w;
        logic [31:0] wword;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    bit          load_mem;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_wdata = '0;
    logic [7:0]  refb [0:255];
    logic [31:0] dmem [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    // DataMemory model: registered read, write on the clock edge
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++)
                dmem[i] <= {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]};
        end else begin
            if (Mem_write) dmem[Mem_address[7:2]] <= Write_data;
            if (Mem_read)  Read_Data <= dmem[Mem_address[7:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rword(input int base);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w = w | (32'(refb[base+k]) << (8*k));
        return w;
    endfunction

    // Reference model: expected behaviour of one accepted request
    function automatic exp_t build(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                                   input logic [31:0] addr, input logic [31:0] wd, input bit commit);
        exp_t        e;
        int          a, base, nb;
        longint      v;
        logic [31:0] w;
        a    = int'(addr[7:0]);
        base = a - (a % 4);
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        a    = a - (a % nb);
        e.acc      = cyc;
        e.is_load  = ld;
        e.is_store = st && !ld;
        e.needs_rd = ld || (nb < 4);
        e.lat      = ld ? 3 : ((nb == 4) ? 2 : 4);
        e.addr_w   = addr & ~32'h3;
        e.rdata    = '0;
        e.wword    = '0;
        if (ld) begin
            v = 0;
            for (int k = 0; k < nb; k++) v += longint'(refb[a+k]) << (8*k);
            if (!uns && nb < 4 && v >= (longint'(1) << (8*nb-1))) v -= (longint'(1) << (8*nb));
            e.rdata = 32'(v);
        end else begin
            w = rword(base);
            for (int k = 0; k < nb; k++) w[8*(a-base+k) +: 8] = wd[8*k +: 8];
            e.wword = w;
            if (commit) for (int k = 0; k < 4; k++) refb[base+k] = w[8*k +: 8];
        end
        return e;
    endfunction

    // Monitor: compares every cycle against the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            last_rdata = '0;
        end else if (mon_en) begin
            chk("rd_wr_exclusive", 32'(Mem_read & Mem_write), 32'd0);
            if (Mem_write) last_wdata = Write_data;
            if (exp_q.size() == 0) begin
                chk("idle_stall", 32'(stall), 32'd0);
                chk("idle_mem_read", 32'(Mem_read), 32'd0);
                chk("idle_mem_write", 32'(Mem_write), 32'd0);
                chk("idle_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                e = exp_q[0];
                chk("stall", 32'(stall), 32'(cyc < e.acc + e.lat));
                chk("mem_read", 32'(Mem_read), 32'(e.needs_rd && cyc == e.acc + 1));
                chk("mem_write", 32'(Mem_write),
                    32'(e.is_store && cyc == e.acc + (e.needs_rd ? 3 : 1)));
                if (Mem_read || Mem_write) chk("mem_address", Mem_address, e.addr_w);
                if (Mem_write) chk("write_data", Write_data, e.wword);
                chk("resp_valid", 32'(resp_valid), 32'(cyc == e.acc + e.lat));
                if (resp_valid) begin
                    chk("resp_rdata", resp_rdata, e.is_load ? e.rdata : last_rdata);
                    if (e.is_load) last_rdata = e.rdata;
                    void'(exp_q.pop_front());
                end else if (cyc > e.acc + e.lat) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Present one request, check the accept-cycle flags, hold until the response
    task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
        bit go, mis;
        int k;
        @(posedge clk); #1;
        req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        go  = ld || st;
        mis = (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
        if (go && !mis) exp_q.push_back(build(ld, st, sz, uns, addr, wd, 1'b1));
        @(negedge clk);
        chk("accept_stall", 32'(stall), 32'(go && !mis));
        chk("misalign_err", 32'(misalign_err), 32'(go && mis));
        got = '0;
        if (go && !mis) begin
            k = 0;
            while (!resp_valid && k < 8) begin
                @(negedge clk);
                k++;
            end
            chk("resp_timeout", 32'(resp_valid), 32'd1);
            got = resp_rdata;
        end
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
        chk({tag, "_mem_read"}, 32'(Mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(Mem_write), 32'd0);
        chk({tag, "_mem_address"}, Mem_address, 32'd0);
        chk({tag, "_write_data"}, Write_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, a, wd;
        logic [1:0]  sz;
        bit          ld, st, uns;
        exp_t        e;

        reset = 1'b1; load_mem = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) refb[i] = 8'($urandom);

        // Reset held 10 cycles, outputs idle throughout and after release
        repeat (10) begin
            @(negedge clk);
            chk_reset_outputs("in_reset");
        end
        @(posedge clk); #1;
        reset = 1'b0; load_mem = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_reset_outputs("post_reset");
        end
        mon_en = 1'b1;

        // sw then lw
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, got);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        issue(1, 0, 2'b10, 0, 32'h10, 32'h0, got);
        chk("lw_deadbeef", got, 32'hDEADBEEF);

        // sb read-modify-write, then signed/unsigned byte loads
        issue(0, 1, 2'b10, 0, 32'h10, 32'h11223344, got);
        issue(0, 1, 2'b00, 0, 32'h13, 32'h000000A5, got);
        chk("sb_merge", last_wdata, 32'hA5223344);
        issue(1, 0, 2'b00, 0, 32'h13, 32'h0, got);
        chk("lb_13", got, 32'hFFFFFFA5);
        issue(1, 0, 2'b00, 1, 32'h13, 32'h0, got);
        chk("lbu_13", got, 32'h000000A5);

        // half loads and sh merge
        issue(1, 0, 2'b01, 0, 32'h12, 32'h0, got);
        chk("lh_12", got, 32'hFFFFA522);
        issue(1, 0, 2'b01, 1, 32'h12, 32'h0, got);
        chk("lhu_12", got, 32'h0000A522);
        issue(0, 1, 2'b01, 0, 32'h10, 32'h0000BEEF, got);
        chk("sh_merge", last_wdata, 32'hA522BEEF);
        issue(1, 1, 2'b11, 0, 32'h10, 32'h0, got);
        chk("ld_wins_size3", got, 32'hA522BEEF);

        // Misaligned requests: flagged, no memory traffic
        issue(1, 0, 2'b10, 0, 32'h06, 32'h0, got);
        issue(0, 1, 2'b01, 0, 32'h11, 32'h1234, got);
        repeat (5) begin
            @(negedge clk);
            chk("misalign_no_read", 32'(Mem_read), 32'd0);
            chk("misalign_no_write", 32'(Mem_write), 32'd0);
        end
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, got);

        // Reset pulsed during RDWAIT of an sb: no write, memory unchanged
        @(posedge clk); #1;
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h5A;
        e = build(0, 1, 2'b00, 0, 32'h20, 32'h5A, 1'b0);
        exp_q.push_back(e);
        @(negedge clk);
        chk("rst_sb_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_sb_read", 32'(Mem_read), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_after_write", 32'(Mem_write), 32'd0);
            chk("rst_after_resp", 32'(resp_valid), 32'd0);
            chk("rst_after_rdata", resp_rdata, 32'd0);
        end
        issue(1, 0, 2'b10, 0, 32'h20, 32'h0, got);
        chk("rst_lw_orig", got, rword(32'h20));

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: @(posedge clk);
                1: issue(0, 0, 2'($urandom), 0, $urandom, $urandom, got);
                default: begin
                    ld  = 1'($urandom);
                    st  = ld ? 1'($urandom) : 1'b1;
                    sz  = 2'($urandom);
                    uns = 1'($urandom);
                    a   = $urandom;
                    wd  = $urandom;
                    if ($urandom_range(0, 3) != 0) begin
                        if (sz == 2'b01) a[0] = 1'b0;
                        if (sz[1])       a[1:0] = 2'b00;
                    end
                    issue(ld, st, sz, uns, a, wd, got);
                end
            endcase
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
